// File: rtl/bch_divider_arbiter.sv
// bch_divider_arbiter: shares one Fermat-inverse GF(2^M) divider among N_REQ requesters.
// Optional CONFIG_DIV_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed lowest-index priority.
`default_nettype none

module finite_divider #(
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         start,
  input  logic [M-1:0] standard_denom,
  input  logic [M-1:0] standard_numer,
  output logic         busy,
  output logic [M-1:0] dual_out
);
  localparam int CW = (M > 2) ? $clog2(M) : 1;

  function automatic int bch_polynomial(input int m);
    case (m)
      2: return 'h3;     3: return 'h3;     4: return 'h3;     5: return 'h5;
      6: return 'h3;     7: return 'h9;     8: return 'h1D;    9: return 'h11;
      10: return 'h9;    11: return 'h5;    12: return 'h53;   13: return 'h1B;
      14: return 'h443;  15: return 'h3;    default: return 'h100B;
    endcase
  endfunction

  localparam logic [M-1:0] POLY = M'(bch_polynomial(M));

  function automatic logic [M-1:0] xtime(input logic [M-1:0] a);
    return {a[M-2:0], 1'b0} ^ (a[M-1] ? POLY : '0);
  endfunction

  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] p, aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Trace lands in GF(2): the sum is either all-zero or exactly 1.
  function automatic logic trace(input logic [M-1:0] y);
    logic [M-1:0] s, t;
    s = y;
    t = y;
    for (int k = 1; k < M; k++) begin
      s = gf_mul(s, s);
      t = t ^ s;
    end
    return |t;
  endfunction

  logic [M-1:0]  sq, acc, quot;
  logic [CW-1:0] cnt;

  // acc accumulates a^2 * a^4 * ... * a^(2^(M-1)) = a^(2^M-2) = a^-1.
  always_ff @(posedge clk) begin
    if (start) begin
      sq  <= gf_mul(standard_denom, standard_denom);
      acc <= M'(1);
      cnt <= CW'(M - 1);
    end else if (cnt != '0) begin
      acc <= gf_mul(acc, sq);
      sq  <= gf_mul(sq, sq);
      cnt <= cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);
  assign quot = gf_mul(acc, standard_numer);

  // Dual-basis coordinate i of x is Tr(alpha^i * x).
  always_comb begin
    logic [M-1:0] p;
    dual_out = '0;
    p = quot;
    for (int i = 0; i < M; i++) begin
      dual_out[i] = trace(p);
      p = xtime(p);
    end
  end
endmodule

module bch_divider_arbiter #(
  parameter int M     = 4,
  parameter int N_REQ = 2,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [M*N_REQ-1:0] numer,
  input  logic [M*N_REQ-1:0] denom,
  output logic [N_REQ-1:0]   ack,
  output logic               done,
  output logic [ID_W-1:0]    done_id,
  output logic [M-1:0]       result,
  output logic               div_by_zero,
  output logic               idle
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_DIV = 2'd2} state_t;

  state_t          state;
  logic [M-1:0]    numer_q, denom_q, dual_out;
  logic [ID_W-1:0] id_q, win_idx;
  logic            win_valid, busy;

`ifdef CONFIG_DIV_ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] ptr;

  // Scan offsets high to low so the nearest requester after ptr wins.
  always_comb begin
    int idx;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (req[idx]) begin
        win_valid = 1'b1;
        win_idx   = ID_W'(idx);
      end
    end
  end
`else
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        win_valid = 1'b1;
        win_idx   = ID_W'(k);
      end
    end
  end
`endif

  finite_divider #(.M(M)) u_div (
    .clk           (clk),
    .start         (state == S_START),
    .standard_denom(denom_q),
    .standard_numer(numer_q),
    .busy          (busy),
    .dual_out      (dual_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      ack         <= '0;
      done        <= 1'b0;
      result      <= '0;
      done_id     <= '0;
      div_by_zero <= 1'b0;
      numer_q     <= '0;
      denom_q     <= '0;
      id_q        <= '0;
`ifdef CONFIG_DIV_ARB_ROUND_ROBIN_EN
      ptr         <= '0;
`endif
    end else begin
      ack  <= '0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_valid && !busy) begin
            numer_q <= numer[win_idx*M +: M];
            denom_q <= denom[win_idx*M +: M];
            id_q    <= win_idx;
            ack     <= N_REQ'(1) << win_idx;
            state   <= S_START;
`ifdef CONFIG_DIV_ARB_ROUND_ROBIN_EN
            ptr     <= ID_W'((int'(win_idx) + 1) % N_REQ);
`endif
          end
        end
        S_START: state <= S_DIV;
        S_DIV: begin
          if (!busy) begin
            result      <= dual_out;
            done        <= 1'b1;
            done_id     <= id_q;
            div_by_zero <= (denom_q == '0);
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign idle = (state == S_IDLE) && !busy;
endmodule

`default_nettype wire

// File: tb/tb_bch_divider_arbiter.sv
// Directed bench for bch_divider_arbiter, M=4 (x^4+x+1), N_REQ=2.
`default_nettype none

module tb_bch_divider_arbiter;
  localparam int M = 4;
  localparam int N_REQ = 2;
  localparam int ID_W = 1;

  logic               clk = 1'b0;
  logic               reset;
  logic [N_REQ-1:0]   req;
  logic [M*N_REQ-1:0] numer, denom;
  logic [N_REQ-1:0]   ack;
  logic               done;
  logic [ID_W-1:0]    done_id;
  logic [M-1:0]       result;
  logic               div_by_zero;
  logic               idle;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bch_divider_arbiter #(.M(M), .N_REQ(N_REQ)) dut (
    .clk(clk), .reset(reset), .req(req), .numer(numer), .denom(denom),
    .ack(ack), .done(done), .done_id(done_id), .result(result),
    .div_by_zero(div_by_zero), .idle(idle)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(output int n, output logic sawd);
    n = 0;
    sawd = 1'b0;
    do begin
      tick();
      n++;
      if (done) sawd = 1'b1;
    end while (ack == '0 && n < 40);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 40);
  endtask

  initial begin
    int n;
    logic sd;
    logic [1:0] exp_ack;
    reset = 1'b1;
    req   = '0;
    numer = '0;
    denom = '0;
    repeat (20) tick();
    reset = 1'b0;
    check("rst_ack", ack, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_done_id", done_id, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_idle", idle, 1);

    // alpha^5 / alpha^2 = alpha^3 = 0x8, dual image 0x9
    numer = 8'h06; denom = 8'h04; req = 2'b01;
    wait_ack(n, sd);
    check("single_ack", ack, 2'b01);
    check("single_ack_lat", n, 1);
    req = '0;
    wait_done(n);
    check("single_done_lat", n, M + 1);
    check("single_result", result, 4'h9);
    check("single_id", done_id, 0);
    check("single_dbz", div_by_zero, 0);
    check("single_idle_in_done", idle, 1);
    tick();
    check("single_done_pulse", done, 0);
    check("single_result_hold", result, 4'h9);

    // zero denominator
    numer = 8'h05; denom = 8'h00; req = 2'b01;
    wait_ack(n, sd);
    req = '0;
    wait_done(n);
    check("zden_result", result, 0);
    check("zden_dbz", div_by_zero, 1);
    // zero numerator
    numer = 8'h00; denom = 8'h03; req = 2'b01;
    wait_ack(n, sd);
    req = '0;
    wait_done(n);
    check("znum_result", result, 0);
    check("znum_dbz", div_by_zero, 0);

    // alpha / 1 = alpha -> dual 0x4; later numer change must be ignored
    numer = 8'h02; denom = 8'h01; req = 2'b01;
    wait_ack(n, sd);
    req = '0;
    tick();
    numer = 8'h0F;
    wait_done(n);
    check("hold_done_lat", n, M);
    check("hold_result", result, 4'h4);

    // back-to-back: re-raise in done cycle
    numer = 8'h06; denom = 8'h04; req = 2'b01;
    wait_ack(n, sd);
    req = '0;
    wait_done(n);
    req = 2'b01;
    tick();
    check("b2b_ack_spacing", ack, 2'b01);
    req = '0;
    wait_done(n);
    check("b2b_result", result, 4'h9);

    // reset mid-division with a request pending
    req = 2'b01;
    wait_ack(n, sd);
    req = '0;
    tick();
    tick();
    reset = 1'b1;
    req = 2'b01;
    tick();
    reset = 1'b0;
    check("midrst_ack", ack, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    check("midrst_id", done_id, 0);
    check("midrst_dbz", div_by_zero, 0);
    check("midrst_idle_busy", idle, 0);
    wait_ack(n, sd);
    check("midrst_ack_delay", n, 2);
    check("midrst_no_done", sd, 0);
    check("midrst_ack_val", ack, 2'b01);
    req = '0;
    wait_done(n);
    check("midrst_done_lat", n, M + 1);
    check("midrst_result2", result, 4'h9);

    // contention: r1 computes 1/alpha = alpha^14 = 0x9 -> dual 0x1
    numer = 8'h16; denom = 8'h24; req = 2'b11;
    for (int k = 0; k < 3; k++) begin
      wait_ack(n, sd);
`ifdef CONFIG_DIV_ARB_ROUND_ROBIN_EN
      exp_ack = (k % 2 == 1) ? 2'b10 : 2'b01;
`else
      exp_ack = 2'b01;
`endif
      check($sformatf("cont_ack%0d", k), ack, exp_ack);
      if (k > 0) check($sformatf("cont_spacing%0d", k), n, 1);
      wait_done(n);
      if (k == 2) req = '0;
      check($sformatf("cont_lat%0d", k), n, M + 1);
      check($sformatf("cont_id%0d", k), done_id, (exp_ack == 2'b10) ? 1 : 0);
      check($sformatf("cont_result%0d", k), result, (exp_ack == 2'b10) ? 4'h1 : 4'h9);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
